// File: rtl/vx_axi_ram_pkg.sv
// Shared types and constants for the vx_axi_ram_responder AXI4 memory model.
package vx_axi_ram_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // LFSR bit assigned to each gated handshake signal
  localparam int GATE_AW = 0;
  localparam int GATE_W  = 3;
  localparam int GATE_AR = 6;
  localparam int GATE_B  = 9;
  localparam int GATE_R  = 12;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/vx_axi_ram_store.sv
// Dual-port word array: byte-enabled write port, registered read-first read port.
module vx_axi_ram_store
  import vx_axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_BITS  = 12
) (
  input  logic                    clk,
  input  logic                    i_wr_en,
  input  logic [ADDR_BITS-1:0]    i_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_be,
  input  logic                    i_rd_en,
  input  logic [ADDR_BITS-1:0]    i_rd_addr,
  output logic [DATA_WIDTH-1:0]   o_rd_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // NOTE: the array and read register have no reset so they map onto block RAM;
  // non-blocking writes make a same-address read return the old word.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (i_wr_be[b]) r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vx_axi_ram_responder.sv
// AXI4 slave memory model with independent one-burst write and read FSMs.
// Define VX_AXI_RAM_STALL_EN to throttle handshakes with a 16-bit LFSR.
`ifndef XLEN
`define XLEN 32
`endif

module vx_axi_ram_responder
  import vx_axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = `XLEN,
  parameter int ID_WIDTH       = 32,
  parameter int MEM_WORDS_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic [1:0]              s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic [1:0]              s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);

  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] FULL_SIZE = 3'(OFF);
  localparam logic [MEM_WORDS_LOG2-1:0] IDX_ONE = MEM_WORDS_LOG2'(1);

  wr_state_t                 r_wstate;
  logic                      r_awready, r_wready, r_bvalid, r_bvalid_shown, r_werr;
  logic [ID_WIDTH-1:0]       r_bid;
  logic [1:0]                r_bresp;
  logic [MEM_WORDS_LOG2-1:0] r_widx;
  logic [7:0]                r_wlen, r_wcnt;

  rd_state_t                 r_rstate;
  logic                      r_arready, r_rvalid, r_rvalid_shown, r_rlast;
  logic [ID_WIDTH-1:0]       r_rid;
  logic [1:0]                r_rresp;
  logic [MEM_WORDS_LOG2-1:0] r_ridx;
  logic [7:0]                r_rlen, r_rcnt;

  logic [4:0] w_gate;  // {r, b, ar, w, aw}
`ifdef VX_AXI_RAM_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= lfsr_next(r_lfsr);
  end
  assign w_gate = {r_lfsr[GATE_R], r_lfsr[GATE_B], r_lfsr[GATE_AR], r_lfsr[GATE_W], r_lfsr[GATE_AW]};
`else
  assign w_gate = 5'b11111;
`endif

  // A valid may only rise on a gate cycle; once shown it stays until accepted.
  logic w_bvalid, w_rvalid;
  assign w_bvalid = r_bvalid & (r_bvalid_shown | w_gate[3]);
  assign w_rvalid = r_rvalid & (r_rvalid_shown | w_gate[4]);

  assign s_axi_awready = r_awready & w_gate[0];
  assign s_axi_wready  = r_wready & w_gate[1];
  assign s_axi_arready = r_arready & w_gate[2];
  assign s_axi_bvalid  = w_bvalid;
  assign s_axi_rvalid  = w_rvalid;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rid     = r_rid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  assign w_aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_w_hs  = s_axi_wvalid & s_axi_wready;
  assign w_b_hs  = w_bvalid & s_axi_bready;
  assign w_ar_hs = s_axi_arvalid & s_axi_arready;
  assign w_r_hs  = w_rvalid & s_axi_rready;

  logic w_aw_err, w_ar_err, w_wlast_cnt, w_wlast_err;
  assign w_aw_err    = (s_axi_awsize != FULL_SIZE) | (s_axi_awburst != AXI_BURST_INCR);
  assign w_ar_err    = (s_axi_arsize != FULL_SIZE) | (s_axi_arburst != AXI_BURST_INCR);
  assign w_wlast_cnt = (r_wcnt == r_wlen);
  assign w_wlast_err = s_axi_wlast ^ w_wlast_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate       <= W_IDLE;
      r_awready      <= 1'b0;
      r_wready       <= 1'b0;
      r_bvalid       <= 1'b0;
      r_bvalid_shown <= 1'b0;
      r_bresp        <= AXI_RESP_OKAY;
      r_bid          <= '0;
      r_widx         <= '0;
      r_wlen         <= '0;
      r_wcnt         <= '0;
      r_werr         <= 1'b0;
    end else begin
      r_bvalid_shown <= w_bvalid & ~s_axi_bready;
      case (r_wstate)
        W_IDLE: begin
          r_awready <= ~w_aw_hs;
          if (w_aw_hs) begin
            r_bid    <= s_axi_awid;
            r_widx   <= s_axi_awaddr[OFF +: MEM_WORDS_LOG2];
            r_wlen   <= s_axi_awlen;
            r_wcnt   <= '0;
            r_werr   <= w_aw_err;
            r_wready <= 1'b1;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_widx <= r_widx + IDX_ONE;
            r_wcnt <= r_wcnt + 8'd1;
            if (w_wlast_err) r_werr <= 1'b1;
            if (w_wlast_cnt) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_werr | w_wlast_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // The read port is loaded on AR acceptance and on every non-last beat hand-off.
  logic                      w_rd_en;
  logic [MEM_WORDS_LOG2-1:0] w_ar_idx, w_rd_addr;
  assign w_ar_idx  = s_axi_araddr[OFF +: MEM_WORDS_LOG2];
  assign w_rd_en   = w_ar_hs | (w_r_hs & ~r_rlast);
  assign w_rd_addr = (r_rstate == R_IDLE) ? w_ar_idx : r_ridx + IDX_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate       <= R_IDLE;
      r_arready      <= 1'b0;
      r_rvalid       <= 1'b0;
      r_rvalid_shown <= 1'b0;
      r_rlast        <= 1'b0;
      r_rresp        <= AXI_RESP_OKAY;
      r_rid          <= '0;
      r_ridx         <= '0;
      r_rlen         <= '0;
      r_rcnt         <= '0;
    end else begin
      r_rvalid_shown <= w_rvalid & ~s_axi_rready;
      case (r_rstate)
        R_IDLE: begin
          r_arready <= ~w_ar_hs;
          if (w_ar_hs) begin
            r_rid    <= s_axi_arid;
            r_ridx   <= w_ar_idx;
            r_rlen   <= s_axi_arlen;
            r_rcnt   <= '0;
            r_rlast  <= (s_axi_arlen == 8'd0);
            r_rresp  <= w_ar_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            r_rvalid <= 1'b1;
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_ridx  <= r_ridx + IDX_ONE;
              r_rcnt  <= r_rcnt + 8'd1;
              r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
          end
        end
      endcase
    end
  end

  vx_axi_ram_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_BITS (MEM_WORDS_LOG2)
  ) u_store (
    .clk      (clk),
    .i_wr_en  (w_w_hs),
    .i_wr_addr(r_widx),
    .i_wr_data(s_axi_wdata),
    .i_wr_be  (s_axi_wstrb),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(s_axi_rdata)
  );

  logic w_unused;
  assign w_unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                      s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                      s_axi_awaddr, s_axi_araddr};

endmodule

// File: tb/tb_vx_axi_ram_responder.sv
// Scoreboard bench for vx_axi_ram_responder; cycle-exact checks are skipped under VX_AXI_RAM_STALL_EN.
module tb_vx_axi_ram_responder;

  localparam int DW = 512;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_axi_awvalid, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr;
  logic [IW-1:0] s_axi_awid;
  logic [7:0]    s_axi_awlen;
  logic [2:0]    s_axi_awsize;
  logic [1:0]    s_axi_awburst;
  logic          s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata;
  logic [SW-1:0] s_axi_wstrb;
  logic          s_axi_wlast;
  logic          s_axi_bvalid, s_axi_bready;
  logic [IW-1:0] s_axi_bid;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_arvalid, s_axi_arready;
  logic [AW-1:0] s_axi_araddr;
  logic [IW-1:0] s_axi_arid;
  logic [7:0]    s_axi_arlen;
  logic [2:0]    s_axi_arsize;
  logic [1:0]    s_axi_arburst;
  logic          s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_rdata;
  logic [IW-1:0] s_axi_rid;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast;

  vx_axi_ram_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_WORDS_LOG2(12)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awlock(2'b00), .s_axi_awcache(4'h0), .s_axi_awprot(3'b000), .s_axi_awqos(4'h0),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arlock(2'b00), .s_axi_arcache(4'h0), .s_axi_arprot(3'b000), .s_axi_arqos(4'h0),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
  } r_exp_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  r_exp_t        r_q[$];
  b_exp_t        b_q[$];
  logic [DW-1:0] model_mem [int];
  int            vectors = 0;
  int            miscompares = 0;

  function automatic int word_of(input logic [AW-1:0] addr);
    return int'((addr >> 6) & 32'hFFF);
  endfunction

  function automatic logic dut_sig(input int which);
    case (which)
      0:       return s_axi_awready;
      1:       return s_axi_wready;
      2:       return s_axi_bvalid;
      3:       return s_axi_arready;
      4:       return s_axi_rvalid;
      default: return 1'b0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where the signal is seen high.
  task automatic wait_for(input int which, input string name);
    int n = 0;
    while (dut_sig(which) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (dut_sig(which) !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: got %b after %0d cycles, required 1", name, dut_sig(which), n);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [IW-1:0] id, input logic [SW-1:0] strb,
                          input logic [DW-1:0] base, input bit bad_last);
    int            idx = word_of(addr);
    int            k;
    logic [DW-1:0] wd, old;
    b_exp_t        be;
    be.id   = id;
    be.resp = (size != 3'd6 || burst != 2'b01 || bad_last) ? 2'b10 : 2'b00;
    b_q.push_back(be);
    s_axi_awaddr = addr; s_axi_awid = id; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    wait_for(0, "awready");
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wd = base + DW'(i);
      s_axi_wvalid = 1'b1; s_axi_wdata = wd; s_axi_wstrb = strb;
      s_axi_wlast  = (i == int'(len)) ^ bad_last;
      wait_for(1, "wready");
      k   = (idx + i) % 4096;
      old = model_mem.exists(k) ? model_mem[k] : {DW{1'bx}};
      for (int b = 0; b < SW; b++) if (strb[b]) old[8*b +: 8] = wd[8*b +: 8];
      model_mem[k] = old;
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b1;
    wait_for(2, "bvalid");
    be = b_q.pop_front();
    vectors++;
    if (s_axi_bid !== be.id || s_axi_bresp !== be.resp) begin
      miscompares++;
      $display("FAIL b_resp: got id=%h resp=%b, required id=%h resp=%b", s_axi_bid, s_axi_bresp, be.id, be.resp);
    end
    @(negedge clk);
    s_axi_bready = 1'b0;
    vectors++;
    if (s_axi_bvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL b_single: got bvalid=%b after B handshake, required 0", s_axi_bvalid);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [IW-1:0] id, input int hold);
    int     idx = word_of(addr);
    int     n = 0, cyc = 0, first = -1, lastc = 0;
    r_exp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = model_mem[(idx + i) % 4096];
      e.id   = id;
      e.resp = (size != 3'd6 || burst != 2'b01) ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      r_q.push_back(e);
    end
    s_axi_araddr = addr; s_axi_arid = id; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    wait_for(3, "arready");
    @(negedge clk);
    s_axi_arvalid = 1'b0;
`ifndef VX_AXI_RAM_STALL_EN
    vectors++;
    if (s_axi_rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL r_latency: got rvalid=%b one cycle after AR, required 1", s_axi_rvalid);
    end
`endif
    wait_for(4, "rvalid");
    for (int h = 0; h < hold; h++) begin
      vectors++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== r_q[0].data || s_axi_rid !== id) begin
        miscompares++;
        $display("FAIL r_hold: got rvalid=%b rid=%h rdata=%h, required 1 %h %h",
                 s_axi_rvalid, s_axi_rid, s_axi_rdata, id, r_q[0].data);
      end
      @(negedge clk);
    end
    s_axi_rready = 1'b1;
    while (r_q.size() > 0 && n < 500) begin
      if (s_axi_rvalid === 1'b1) begin
        e = r_q.pop_front();
        vectors++;
        if (s_axi_rdata !== e.data || s_axi_rid !== e.id || s_axi_rresp !== e.resp || s_axi_rlast !== e.last) begin
          miscompares++;
          $display("FAIL r_beat: got data=%h id=%h resp=%b last=%b, required %h %h %b %b",
                   s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, e.data, e.id, e.resp, e.last);
        end
        if (first < 0) first = cyc;
        lastc = cyc;
      end
      @(negedge clk);
      cyc++;
      n++;
    end
    s_axi_rready = 1'b0;
    if (r_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL r_timeout: got %0d beats missing, required 0", r_q.size());
      r_q.delete();
    end
    vectors++;
    if (s_axi_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL r_done: got rvalid=%b after last beat, required 0", s_axi_rvalid);
    end
`ifndef VX_AXI_RAM_STALL_EN
    vectors++;
    if (lastc - first != int'(len) || s_axi_arready !== 1'b1) begin
      miscompares++;
      $display("FAIL r_back_to_back: got span=%0d arready=%b, required %0d 1", lastc - first, s_axi_arready, len);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
         s_axi_bresp, s_axi_rresp} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_values: got aw=%b w=%b b=%b ar=%b r=%b rlast=%b bresp=%b rresp=%b, required all 0",
               s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
               s_axi_bresp, s_axi_rresp);
    end
    reset = 1'b0;
    @(negedge clk);
`ifndef VX_AXI_RAM_STALL_EN
    vectors++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: got awready=%b arready=%b, required 1 1", s_axi_awready, s_axi_arready);
    end
`endif
  endtask

  task automatic test_burst();
    do_write(32'h40, 8'd3, 3'd6, 2'b01, 32'h11, {SW{1'b1}}, 512'd1, 1'b0);
    do_read(32'h40, 8'd3, 3'd6, 2'b01, 32'h22, 0);
  endtask

  task automatic test_byte_strobe();
    do_write(32'h80, 8'd0, 3'd6, 2'b01, 32'h33, {SW{1'b1}}, {DW{1'b1}}, 1'b0);
    do_write(32'h80, 8'd0, 3'd6, 2'b01, 32'h34, 64'h1, 512'hA5, 1'b0);
    vectors++;
    if (model_mem[2] !== {{(DW-8){1'b1}}, 8'hA5}) begin
      miscompares++;
      $display("FAIL strobe_model: got %h, required byte0 a5 rest ff", model_mem[2]);
    end
    do_read(32'h80, 8'd0, 3'd6, 2'b01, 32'h35, 0);
  endtask

  task automatic test_backpressure();
    do_read(32'h40, 8'd1, 3'd6, 2'b01, 32'hBEEF, 5);
  endtask

  task automatic test_error();
    do_write(32'h100, 8'd1, 3'd2, 2'b00, 32'h44, {SW{1'b1}}, 512'h1000, 1'b0);
    do_read(32'h100, 8'd1, 3'd6, 2'b01, 32'h45, 0);
    do_read(32'h100, 8'd1, 3'd2, 2'b01, 32'h46, 0);
    do_write(32'h200, 8'd1, 3'd6, 2'b01, 32'h47, {SW{1'b1}}, 512'h2000, 1'b1);
    do_read(32'h200, 8'd1, 3'd6, 2'b00, 32'h48, 0);
  endtask

  task automatic test_wrap();
    do_write(32'h3FFC0, 8'd1, 3'd6, 2'b01, 32'h55, {SW{1'b1}}, 512'h5000, 1'b0);
    do_read(32'h3FFC0, 8'd1, 3'd6, 2'b01, 32'h56, 0);
    do_read(32'h0, 8'd0, 3'd6, 2'b01, 32'h57, 0);
    do_read(32'h40045, 8'd0, 3'd6, 2'b01, 32'h58, 0);
  endtask

  task automatic test_reset_mid_burst();
    int n = 0, beats = 0;
    s_axi_araddr = 32'h40; s_axi_arid = 32'h66; s_axi_arlen = 8'd3;
    s_axi_arsize = 3'd6; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    wait_for(3, "arready");
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    while (beats < 1 && n < 200) begin
      if (s_axi_rvalid === 1'b1) beats++;
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    s_axi_rready = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0 || s_axi_rlast !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got rvalid=%b arready=%b rlast=%b, required 0 0 0",
               s_axi_rvalid, s_axi_arready, s_axi_rlast);
    end
    reset = 1'b0;
    @(negedge clk);
`ifndef VX_AXI_RAM_STALL_EN
    vectors++;
    if (s_axi_arready !== 1'b1 || s_axi_awready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_release: got arready=%b awready=%b rvalid=%b, required 1 1 0",
               s_axi_arready, s_axi_awready, s_axi_rvalid);
    end
`endif
    do_read(32'h40, 8'd3, 3'd6, 2'b01, 32'h67, 0);
  endtask

  initial begin
    reset = 1'b1;
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0;
    s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0;
    s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_rready = 1'b0;
    test_reset();
    test_burst();
    test_byte_strobe();
    test_backpressure();
    test_error();
    test_wrap();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion by 5 ms, required finish");
    $fatal(1);
  end

endmodule

// File: doc/vx_axi_ram_responder.md
Name: vx_axi_ram_responder

Overview:
AXI4 slave memory model that answers the Vortex AXI4 master memory port: AW/W/B and AR/R channels, backed by a byte-enabled dual-port word array.
Used as the memory endpoint in FPGA/simulation test projects, in place of the platform DDR.
Read and write paths are independent FSMs. Each path holds one outstanding burst and runs at full throughput (one beat per cycle).

Parameters:
DATA_WIDTH, 512, AXI data width in bits; power of two, at least 32.
ADDR_WIDTH, `XLEN, AXI byte address width.
ID_WIDTH, 32, AXI transaction ID width.
MEM_WORDS_LOG2, 12, log2 of array depth in DATA_WIDTH words.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_axi_awvalid/awready  in/out  1/1  write address handshake
s_axi_awaddr  in  ADDR_WIDTH  burst start byte address
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awlen/awsize/awburst  in  8/3/2  beats-1, beat size, burst type
s_axi_awlock/awcache/awprot/awqos, s_axi_arlock/arcache/arprot/arqos  in  2/4/3/4  accepted and ignored
s_axi_wvalid/wready  in/out  1/1  write data handshake
s_axi_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write beat
s_axi_bvalid/bready  out/in  1/1  write response handshake
s_axi_bid/bresp  out  ID_WIDTH/2  response ID, response code
s_axi_arvalid/arready  in/out  1/1  read address handshake
s_axi_araddr/arid/arlen/arsize/arburst  in  ADDR_WIDTH/ID_WIDTH/8/3/2  read burst descriptor
s_axi_rvalid/rready  out/in  1/1  read data handshake
s_axi_rdata/rid/rresp/rlast  out  DATA_WIDTH/ID_WIDTH/2/1  read beat

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp = 0; array contents are not reset.
- awready and arready rise the first cycle after reset deasserts.
- Reset mid-burst abandons the burst with no response, and both FSMs return to idle.
- Word index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)] modulo 2^MEM_WORDS_LOG2. Addresses wrap silently; the low offset bits are ignored.
- Error response: a burst with awsize/arsize != log2(DATA_WIDTH/8), or burst != INCR(2'b01), is still performed as full-width INCR, but bresp/rresp = SLVERR (2'b10). Otherwise OKAY (2'b00).
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. AW handshake latches id, index, len, error flag; go to W_DATA.
  - W_DATA: wready=1. Each beat writes the bytes with wstrb set and increments index (wrapping).
  - Leaving W_DATA: the beat with counter==len goes to W_RESP. wlast is not used for counting; a wlast/count mismatch forces SLVERR.
  - W_RESP: bvalid=1 held until bready, then W_IDLE. No new AW is accepted until the B handshake completes.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. AR handshake latches descriptor and registers word[index] into rdata; rvalid rises the next cycle (1-cycle latency).
  - R_DATA: rvalid held with stable rdata/rid/rresp/rlast while rready=0.
  - Non-last handshake reloads rdata from index+1 on the same edge, giving back-to-back beats.
  - rlast=1 exactly on beat len. Its handshake returns to R_IDLE; arready is reasserted the following cycle.
- Same-word read and write in the same cycle: read returns the old data (read-first).
- AW and W may arrive in the same cycle only after AW is accepted. W beats presented while in W_IDLE stall, since wready=0.

Optional Feature:
VX_AXI_RAM_STALL_EN:
- When defined: a 16-bit LFSR (seed 16'hACE1, reset to seed) gates awready, wready, arready, bvalid and rvalid. Each is suppressed on cycles where its assigned LFSR bit is 0.
- Gating never drops an asserted valid or changes its payload.
- When undefined: no gating; the timing is exactly as above.

Decomposition:
- Package vx_axi_ram_pkg: write/read state enums, AXI_RESP_OKAY/AXI_RESP_SLVERR, AXI_BURST_INCR, LFSR seed/taps.
- Sub-module vx_axi_ram_store: dual-port array, write port with byte enables, synchronous read-first read port.

Test Plan:
1. AW addr=0x40, len=3, size=6, INCR; 4 W beats, wstrb all ones, data 1..4 -> bresp=0, one B. Then AR same -> rdata 1,2,3,4 on consecutive cycles, rlast on 4th, rresp=0.
2. Write word 0x80 with wstrb=64'h1 over old 0xFF..FF -> readback has byte0 new, all other bytes 0xFF.
3. AR len=1 with rready held low 5 cycles -> rvalid stays 1, rdata/rid stable, no beat loss.
4. AW arsize=2 burst FIXED -> data written as INCR, bresp=2'b10. Read with wrong arsize -> rresp=2'b10 on every beat.
5. Burst starting at the last word, len=1 -> second beat wraps to word 0.
6. Reset asserted during read beat 2 of 4 -> rvalid=0 next cycle, arready=1 the cycle after reset release. With VX_AXI_RAM_STALL_EN, scenario 1 passes with identical data.
